// File: rtl/clk_mgmt_pkg.sv
// Shared definitions for the clock-management block.
// Contents:
//   state_t           - supervisor FSM state encoding (2 bits)
//   DEF_*             - default timing parameters for clk_lock_supervisor
//   EVT_CNT_W         - width of the saturating event counters
//   sat_inc()         - saturating increment for an event counter
package clk_mgmt_pkg;

  typedef enum logic [1:0] {
    ST_RESET_MMCM  = 2'd0,
    ST_WAIT_LOCK   = 2'd1,
    ST_STABLE_WAIT = 2'd2,
    ST_RUNNING     = 2'd3
  } state_t;

  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT  = 4000;  // 100 us at 40 MHz
  localparam int DEF_STABLE_CYCLES = 1024;

  localparam int EVT_CNT_W = 8;

  // Holds at all-ones so slow control never sees a wrapped count.
  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (&v) ? v : v + EVT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/clk_lock_supervisor_if.sv
// Signal bundle between the MMCM lock supervisor and its surroundings
// (MMCM status/reset pins, slow control, system reset fan-out).
//   mmcm_locked     MMCM LOCKED, asynchronous to the supervisor clock
//   soft_reset_req  one-cycle request from slow control
//   mmcm_rst        reset request to the MMCM, active-high
//   sys_rst         system reset, active-high
//   clk_good        high only while the clock is trusted
//   relock_count    lock losses seen while running (saturating)
//   timeout_count   lock timeouts (saturating)
//   state           current supervisor state, for observation only
// Handshake: there is no valid/ready pair here. soft_reset_req is a
// fire-and-forget pulse that is acted on in the cycle it is sampled high;
// the supervisor never back-pressures it, and a pulse that arrives while the
// MMCM is already being reset is dropped.
interface clk_lock_supervisor_if;
  import clk_mgmt_pkg::*;

  logic                 mmcm_locked;
  logic                 soft_reset_req;
  logic                 mmcm_rst;
  logic                 sys_rst;
  logic                 clk_good;
  logic [EVT_CNT_W-1:0] relock_count;
  logic [EVT_CNT_W-1:0] timeout_count;
  state_t               state;

  // Environment side: drives MMCM status and slow-control requests.
  modport master (
    output mmcm_locked, soft_reset_req,
    input  mmcm_rst, sys_rst, clk_good, relock_count, timeout_count, state
  );

  // Supervisor side.
  modport slave (
    input  mmcm_locked, soft_reset_req,
    output mmcm_rst, sys_rst, clk_good, relock_count, timeout_count, state
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow, level-type status inputs.
//   clk  destination clock
//   rst  synchronous active-high reset, clears both stages
//   d    asynchronous input
//   q    synchronised output (two clk edges of latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_lock_supervisor.sv
// MMCM lock supervisor, running on the free-running board oscillator.
// Pulses the MMCM reset, waits for LOCKED, requires lock to hold for a
// stable period before releasing the system reset, and re-initialises the
// MMCM on lock loss, lock timeout or a slow-control request.
// Ports:
//   CLK_40M  free-running 40 MHz oscillator (never an MMCM output)
//   rst      synchronous active-high reset
//   bus      clk_lock_supervisor_if.slave: MMCM status/reset, slow-control
//            request, system reset, clk_good, event counters, state
module clk_lock_supervisor
  import clk_mgmt_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic                  CLK_40M,
  input  logic                  rst,
  clk_lock_supervisor_if.slave  bus
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic                 lock_s;
  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 init_q;
  logic                 timeout_evt, relock_evt;
  logic                 mmcm_rst_q, sys_rst_q, clk_good_q;
  logic [EVT_CNT_W-1:0] relock_q, timeout_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (CLK_40M),
    .rst (rst),
    .d   (bus.mmcm_locked),
    .q   (lock_s)
  );

  // A soft request outranks every other exit; it is ignored in RESET_MMCM
  // so the MMCM reset pulse is never stretched.
  always_comb begin
    next_state  = state;
    timeout_evt = 1'b0;
    relock_evt  = 1'b0;
    case (state)
      ST_RESET_MMCM: begin
        if (!init_q && cnt == RST_LAST) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (bus.soft_reset_req)    next_state = ST_RESET_MMCM;
        else if (lock_s)           next_state = ST_STABLE_WAIT;  // lock beats timeout
        else if (cnt == TIMEOUT_LAST) begin
          next_state  = ST_RESET_MMCM;
          timeout_evt = 1'b1;
        end
      end
      ST_STABLE_WAIT: begin
        if (bus.soft_reset_req || !lock_s) next_state = ST_RESET_MMCM;
        else if (cnt == STABLE_LAST)       next_state = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (bus.soft_reset_req) next_state = ST_RESET_MMCM;
        else if (!lock_s) begin
          next_state = ST_RESET_MMCM;
          relock_evt = 1'b1;
        end
      end
      default: next_state = ST_RESET_MMCM;
    endcase
  end

  // init_q marks the first cycle after reset: it counts as the entry cycle of
  // RESET_MMCM, so the first MMCM reset pulse is as long as any later one.
  // cnt is free to wrap in RUNNING; nothing reads it there.
  always_ff @(posedge CLK_40M) begin
    if (rst) begin
      state      <= ST_RESET_MMCM;
      cnt        <= '0;
      init_q     <= 1'b1;
      mmcm_rst_q <= 1'b1;
      sys_rst_q  <= 1'b1;
      clk_good_q <= 1'b0;
      relock_q   <= '0;
      timeout_q  <= '0;
    end else begin
      init_q     <= 1'b0;
      state      <= next_state;
      cnt        <= (init_q || next_state != state) ? '0 : cnt + CNT_W'(1);
      mmcm_rst_q <= (next_state == ST_RESET_MMCM);
      sys_rst_q  <= (next_state != ST_RUNNING);
      clk_good_q <= (next_state == ST_RUNNING);
      if (relock_evt)  relock_q  <= sat_inc(relock_q);
      if (timeout_evt) timeout_q <= sat_inc(timeout_q);
    end
  end

  assign bus.mmcm_rst      = mmcm_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.clk_good      = clk_good_q;
  assign bus.relock_count  = relock_q;
  assign bus.timeout_count = timeout_q;
  assign bus.state         = state;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Bench for clk_lock_supervisor with RST_CYCLES=8, LOCK_TIMEOUT=64,
// STABLE_CYCLES=16. Edge n is the n-th rising edge after rst is released
// (edge 0 is the first edge with rst=0); outputs are sampled 1 ns after it.
module tb_clk_lock_supervisor;
  import clk_mgmt_pkg::*;

  logic CLK_40M = 1'b0;
  logic rst     = 1'b1;
  int   edge_n  = -1;
  int   checks  = 0;
  int   errors  = 0;

  clk_lock_supervisor_if bus();

  clk_lock_supervisor #(
    .RST_CYCLES    (8),
    .LOCK_TIMEOUT  (64),
    .STABLE_CYCLES (16),
    .CNT_W         (16)
  ) dut (
    .CLK_40M (CLK_40M),
    .rst     (rst),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 CLK_40M = ~CLK_40M;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK_40M);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string tag, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s at edge %0d: got %0d expected %0d", tag, field, edge_n, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input state_t st, input logic mr,
                           input logic sr, input logic cg,
                           input logic [7:0] rc, input logic [7:0] tc);
    cmp(tag, "state",         int'(bus.state),         int'(st));
    cmp(tag, "mmcm_rst",      int'(bus.mmcm_rst),      int'(mr));
    cmp(tag, "sys_rst",       int'(bus.sys_rst),       int'(sr));
    cmp(tag, "clk_good",      int'(bus.clk_good),      int'(cg));
    cmp(tag, "relock_count",  int'(bus.relock_count),  int'(rc));
    cmp(tag, "timeout_count", int'(bus.timeout_count), int'(tc));
  endtask

  // ---------------- bring-up vector table ----------------
  typedef struct {
    int         edge_n;     // edge after which outputs are checked
    logic       lock_next;  // mmcm_locked driven right after that edge
    state_t     exp_state;
    logic       exp_mr;
    logic       exp_sr;
    logic       exp_cg;
    logic [7:0] exp_rc;
    logic [7:0] exp_tc;
  } vec_t;

  vec_t vecs [9];

  // ---------------- test sequence ----------------
  initial begin
    // lock rises before edge 20 -> STABLE_WAIT at 22, RUNNING at 38
    vecs[0] = '{0,  1'b0, ST_RESET_MMCM,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{7,  1'b0, ST_RESET_MMCM,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[2] = '{8,  1'b0, ST_WAIT_LOCK,   1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[3] = '{19, 1'b1, ST_WAIT_LOCK,   1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[4] = '{21, 1'b1, ST_WAIT_LOCK,   1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[5] = '{22, 1'b1, ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[6] = '{37, 1'b1, ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vecs[7] = '{38, 1'b1, ST_RUNNING,     1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[8] = '{45, 1'b1, ST_RUNNING,     1'b0, 1'b0, 1'b1, 8'd0, 8'd0};

    bus.mmcm_locked    = 1'b0;
    bus.soft_reset_req = 1'b0;

    // reset held for a few edges, values checked during and just after
    for (int i = 0; i < 4; i++) tick();
    check_all("in_rst", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    rst    = 1'b0;
    edge_n = -1;
    check_all("after_rst", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);

    // normal bring-up from the table
    foreach (vecs[i]) begin
      run_to(vecs[i].edge_n);
      check_all($sformatf("bringup[%0d]", i), vecs[i].exp_state, vecs[i].exp_mr,
                vecs[i].exp_sr, vecs[i].exp_cg, vecs[i].exp_rc, vecs[i].exp_tc);
      bus.mmcm_locked = vecs[i].lock_next;
    end

    // lock loss in RUNNING: falls before edge 50 -> reset at edge 52
    run_to(49);
    bus.mmcm_locked = 1'b0;
    run_to(51);
    check_all("loss_51", ST_RUNNING, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    run_to(52);
    check_all("loss_52", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    // re-bring-up: lock before edge 66 -> STABLE at 68, RUNNING at 84
    run_to(59);
    check_all("rebring_59", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(60);
    check_all("rebring_60", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(65);
    bus.mmcm_locked = 1'b1;
    run_to(68);
    check_all("rebring_68", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(83);
    check_all("rebring_83", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(84);
    check_all("rebring_84", ST_RUNNING, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);

    // soft reset in RUNNING, then a repeat pulse inside RESET_MMCM
    run_to(90);
    bus.soft_reset_req = 1'b1;
    run_to(91);
    bus.soft_reset_req = 1'b0;
    check_all("soft_91", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(93);
    bus.soft_reset_req = 1'b1;
    run_to(94);
    bus.soft_reset_req = 1'b0;
    run_to(98);
    check_all("soft_98", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(99);
    check_all("soft_99", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(100);
    check_all("soft_100", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);

    // glitch in STABLE_WAIT at cnt=10 (edge 110), three cycles long
    run_to(110);
    bus.mmcm_locked = 1'b0;
    run_to(112);
    check_all("glitch_112", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(113);
    bus.mmcm_locked = 1'b1;
    check_all("glitch_113", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(116);
    check_all("glitch_116", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(121);
    check_all("glitch_121", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(122);
    check_all("glitch_122", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(137);
    check_all("glitch_137", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(138);
    check_all("glitch_138", ST_RUNNING, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);

    // rst asserted mid-STABLE_WAIT
    run_to(140);
    bus.soft_reset_req = 1'b1;
    run_to(141);
    bus.soft_reset_req = 1'b0;
    run_to(150);
    check_all("pre_rst_150", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(155);
    rst = 1'b1;
    run_to(156);
    check_all("mid_rst", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(157);
    rst    = 1'b0;
    edge_n = -1;
    check_all("post_rst", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    // lock already high: synchroniser restarts, lock_s from edge 1
    run_to(0);
    check_all("restart_0", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(7);
    check_all("restart_7", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(8);
    check_all("restart_8", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(9);
    check_all("restart_9", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(24);
    check_all("restart_24", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    run_to(25);
    check_all("restart_25", ST_RUNNING, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

    // no lock: lock falls before edge 31 -> RESET at 33, WAIT at 41
    run_to(30);
    bus.mmcm_locked = 1'b0;
    run_to(33);
    check_all("nolock_33", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(104);
    check_all("nolock_104", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run_to(105);
    check_all("nolock_105", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    run_to(112);
    check_all("nolock_112", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    run_to(113);
    check_all("nolock_113", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
    run_to(176);
    check_all("nolock_176", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
    run_to(177);
    check_all("nolock_177", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);

    // lock_s first high in the cnt==63 cycle of WAIT_LOCK (WAIT from 185)
    run_to(246);
    bus.mmcm_locked = 1'b1;
    run_to(248);
    check_all("race_248", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
    run_to(249);
    bus.mmcm_locked = 1'b0;
    check_all("race_249", ST_STABLE_WAIT, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
    run_to(252);
    check_all("race_252", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);

    // timeouts resume: n-th at edge 324 + 72*(n-3), saturating at 255
    run_to(324);
    check_all("sat_324", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd3);
    run_to(331);
    check_all("sat_331", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd3);
    run_to(332);
    check_all("sat_332", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3);
    run_to(18467);
    check_all("sat_18467", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd254);
    run_to(18468);
    check_all("sat_18468", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd255);
    run_to(18540);
    check_all("sat_18540", ST_RESET_MMCM, 1'b1, 1'b1, 1'b0, 8'd1, 8'd255);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
